// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding / hazard unit.
//   FWD_* : operand-mux select encodings
//   stage_t : in-flight instruction record {v, w, m2, rn} at the default register width
package fwd_pkg;

    localparam int unsigned FWD_AW = 5;

    localparam logic [1:0] FWD_REG      = 2'b00;
    localparam logic [1:0] FWD_EX       = 2'b01;
    localparam logic [1:0] FWD_MEM_ALU  = 2'b10;
    localparam logic [1:0] FWD_MEM_LOAD = 2'b11;

    typedef struct packed {
        logic              v;
        logic              w;
        logic              m2;
        logic [FWD_AW-1:0] rn;
    } stage_t;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage / hazard-unit signal bundle.
//   master : pipeline side, drives decode info, flush and mem_ready; reads fwd/stall/freeze
//   slave  : hazard unit side
// With FWD_STALL_CNT_EN defined the bundle also carries stall_cnt / freeze_cnt (CW bits).
interface fwd_hazard_unit_if
    import fwd_pkg::*;
#(
    parameter int unsigned NPORTS = 2,
    parameter int unsigned AW     = FWD_AW
`ifdef FWD_STALL_CNT_EN
    , parameter int unsigned CW   = 16
`endif
);
    logic                   d_valid;
    logic                   d_wreg;
    logic                   d_m2reg;
    logic [AW-1:0]          d_rn;
    logic [NPORTS*AW-1:0]   d_rs;
    logic [NPORTS-1:0]      d_use;
    logic                   flush;
    logic                   mem_ready;
    logic [2*NPORTS-1:0]    fwd;
    logic                   stall;
    logic                   freeze;
`ifdef FWD_STALL_CNT_EN
    logic [CW-1:0]          stall_cnt;
    logic [CW-1:0]          freeze_cnt;
`endif

    modport master (
        output d_valid, d_wreg, d_m2reg, d_rn, d_rs, d_use, flush, mem_ready,
`ifdef FWD_STALL_CNT_EN
        input  stall_cnt, freeze_cnt,
`endif
        input  fwd, stall, freeze
    );

    modport slave (
        input  d_valid, d_wreg, d_m2reg, d_rn, d_rs, d_use, flush, mem_ready,
`ifdef FWD_STALL_CNT_EN
        output stall_cnt, freeze_cnt,
`endif
        output fwd, stall, freeze
    );

endinterface

// File: rtl/fwd_port_sel.sv
// Forwarding select for one decode-stage source operand (combinational).
//   rs, use_rs     : source register and whether it is actually read
//   e_rec, m_rec   : EX / MEM shadow records {v, w, m2, rn}
//   sel            : operand-mux select (FWD_* encoding)
//   load_use       : operand needs the result of a load still in EX
module fwd_port_sel
    import fwd_pkg::*;
#(
    parameter  int unsigned AW = FWD_AW,
    localparam int unsigned RW = AW + 3
) (
    input  logic [AW-1:0] rs,
    input  logic          use_rs,
    input  logic [RW-1:0] e_rec,
    input  logic [RW-1:0] m_rec,
    output logic [1:0]    sel,
    output logic          load_use
);
    typedef struct packed {
        logic          v;
        logic          w;
        logic          m2;
        logic [AW-1:0] rn;
    } rec_t;

    rec_t e;
    rec_t m;
    logic e_hit;
    logic m_hit;

    assign e = e_rec;
    assign m = m_rec;
    assign e_hit = e.v & e.w & (e.rn == rs);
    assign m_hit = m.v & m.w & (m.rn == rs);

    // EX beats MEM; r0 never forwards so a tracked write to r0 is harmless
    always_comb begin
        sel      = FWD_REG;
        load_use = 1'b0;
        if (use_rs && (rs != '0)) begin
            if (e_hit) begin
                if (e.m2) load_use = 1'b1;
                else      sel      = FWD_EX;
            end else if (m_hit) begin
                sel = m.m2 ? FWD_MEM_LOAD : FWD_MEM_ALU;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit beside the ID stage.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus (slave)  : decode info, flush, mem_ready in; fwd selects, stall, freeze out
// Keeps EX/MEM shadow records of in-flight writes. fwd/stall/freeze are combinational.
// Optional FWD_STALL_CNT_EN: saturating stall_cnt / freeze_cnt statistics (CW bits).
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned NPORTS = 2,
    parameter int unsigned AW     = FWD_AW
`ifdef FWD_STALL_CNT_EN
    , parameter int unsigned CW   = 16
`endif
) (
    input  logic            clock,
    input  logic            reset,
    fwd_hazard_unit_if.slave bus
);
    typedef struct packed {
        logic          v;
        logic          w;
        logic          m2;
        logic [AW-1:0] rn;
    } rec_t;

    rec_t                e_q;
    rec_t                m_q;
    logic [NPORTS-1:0]   lu_c;
    logic [2*NPORTS-1:0] fwd_c;
    logic                stall_c;
    logic                freeze_c;

    // One select/load-use decoder per source operand
    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        fwd_port_sel #(.AW(AW)) u_sel (
            .rs       (bus.d_rs[p*AW +: AW]),
            .use_rs   (bus.d_use[p]),
            .e_rec    (e_q),
            .m_rec    (m_q),
            .sel      (fwd_c[2*p +: 2]),
            .load_use (lu_c[p])
        );
    end

    // Freeze wins: a load-use stall is only raised once memory is done
    assign freeze_c = m_q.v & m_q.m2 & ~bus.mem_ready;
    assign stall_c  = bus.d_valid & (|lu_c) & ~freeze_c;

    assign bus.fwd    = fwd_c;
    assign bus.stall  = stall_c;
    assign bus.freeze = freeze_c;

    // Shadow pipeline: hold on freeze, else advance with a bubble on stall/flush
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
        end else if (!freeze_c) begin
            m_q <= e_q;
            if (stall_c || bus.flush) begin
                e_q <= '0;
            end else begin
                e_q <= {bus.d_valid, bus.d_wreg, bus.d_m2reg, bus.d_rn};
            end
        end
    end

`ifdef FWD_STALL_CNT_EN
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0] stall_cnt_q;
    logic [CW-1:0] freeze_cnt_q;

    // Saturating statistics, cleared only by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            if (stall_c && (stall_cnt_q != CNT_MAX))   stall_cnt_q  <= stall_cnt_q + CW'(1);
            if (freeze_c && (freeze_cnt_q != CNT_MAX)) freeze_cnt_q <= freeze_cnt_q + CW'(1);
        end
    end

    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.freeze_cnt = freeze_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed vector bench for fwd_hazard_unit (NPORTS=2, AW=5).
module tb_fwd_hazard_unit;

`ifdef FWD_STALL_CNT_EN
    localparam int unsigned CW   = 2;
    localparam int unsigned CMAX = 3;
`endif

    logic clock;
    logic reset;

    fwd_hazard_unit_if #(
        .NPORTS(2), .AW(5)
`ifdef FWD_STALL_CNT_EN
        , .CW(CW)
`endif
    ) bus ();

    fwd_hazard_unit #(
        .NPORTS(2), .AW(5)
`ifdef FWD_STALL_CNT_EN
        , .CW(CW)
`endif
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       dv, dw, dm;
        logic [4:0] rn, rs0, rs1;
        logic [1:0] u;
        logic       fl, mr;
        logic [3:0] efwd;
        logic       est, efz;
    } vec_t;

    localparam int NV = 21;
    vec_t vt[NV];
    int total = 0;
    int bad   = 0;
    int sc    = 0;
    int fc    = 0;

    function automatic vec_t mk(logic dv, logic dw, logic dm, logic [4:0] rn,
                                logic [4:0] rs0, logic [4:0] rs1, logic [1:0] u,
                                logic fl, logic mr, logic [3:0] efwd, logic est, logic efz);
        vec_t r;
        r.dv = dv; r.dw = dw; r.dm = dm; r.rn = rn;
        r.rs0 = rs0; r.rs1 = rs1; r.u = u; r.fl = fl; r.mr = mr;
        r.efwd = efwd; r.est = est; r.efz = efz;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.d_valid   = v.dv;
        bus.d_wreg    = v.dw;
        bus.d_m2reg   = v.dm;
        bus.d_rn      = v.rn;
        bus.d_rs      = {v.rs1, v.rs0};
        bus.d_use     = v.u;
        bus.flush     = v.fl;
        bus.mem_ready = v.mr;
    endtask

    initial begin
        //          dv dw dm rn  rs0 rs1 use   fl mr   fwd{p1,p0} st fz
        vt[0]  = mk(0, 0, 0, 0,  0,  0,  2'b00, 0, 1, 4'b0000, 0, 0); // idle
        vt[1]  = mk(1, 1, 0, 3,  1,  2,  2'b11, 0, 1, 4'b0000, 0, 0); // add r3
        vt[2]  = mk(1, 1, 0, 6,  3,  4,  2'b11, 0, 1, 4'b0001, 0, 0); // r3 from EX
        vt[3]  = mk(1, 0, 0, 0,  6,  3,  2'b11, 0, 1, 4'b1001, 0, 0); // r6 EX, r3 MEM
        vt[4]  = mk(1, 1, 1, 5,  6,  6,  2'b01, 0, 1, 4'b0010, 0, 0); // lw r5; r6 MEM; port1 unused
        vt[5]  = mk(1, 1, 0, 8,  5,  0,  2'b01, 0, 1, 4'b0000, 1, 0); // load-use stall
        vt[6]  = mk(1, 1, 0, 8,  5,  0,  2'b01, 0, 1, 4'b0011, 0, 0); // load data from MEM
        vt[7]  = mk(1, 1, 0, 7,  8,  0,  2'b01, 0, 1, 4'b0001, 0, 0);
        vt[8]  = mk(1, 1, 0, 7,  7,  8,  2'b11, 0, 1, 4'b1001, 0, 0);
        vt[9]  = mk(1, 1, 0, 0,  7,  0,  2'b01, 0, 1, 4'b0001, 0, 0); // E and M both r7: EX wins
        vt[10] = mk(1, 1, 1, 9,  0,  7,  2'b11, 0, 1, 4'b1000, 0, 0); // E writes r0, rs0=0 -> reg
        vt[11] = mk(1, 1, 1, 12, 1,  0,  2'b01, 0, 1, 4'b0000, 0, 0); // lw r12
        vt[12] = mk(1, 1, 0, 13, 12, 9,  2'b11, 0, 0, 4'b1100, 0, 1); // freeze, load-use masked
        vt[13] = mk(1, 1, 0, 13, 12, 9,  2'b11, 0, 0, 4'b1100, 0, 1);
        vt[14] = mk(1, 1, 0, 13, 12, 9,  2'b11, 0, 0, 4'b1100, 0, 1);
        vt[15] = mk(1, 1, 0, 13, 12, 9,  2'b11, 0, 1, 4'b1100, 1, 0); // freeze over, stall now
        vt[16] = mk(1, 1, 0, 13, 12, 9,  2'b11, 0, 1, 4'b0011, 0, 0);
        vt[17] = mk(1, 1, 1, 14, 0,  0,  2'b00, 0, 1, 4'b0000, 0, 0); // lw r14
        vt[18] = mk(1, 1, 0, 15, 14, 0,  2'b01, 1, 1, 4'b0000, 1, 0); // stall + flush
        vt[19] = mk(0, 0, 0, 0,  14, 15, 2'b11, 0, 0, 4'b0011, 0, 1); // load in M, E bubble
        vt[20] = mk(0, 0, 0, 0,  14, 15, 2'b11, 0, 0, 4'b0011, 0, 1);

        reset = 1'b1;
        drive(vt[0]);
        @(negedge clock);
        #1;
        chk("reset fwd", 32'(bus.fwd), 32'h0);
        chk("reset stall", 32'(bus.stall), 32'h0);
        chk("reset freeze", 32'(bus.freeze), 32'h0);
`ifdef FWD_STALL_CNT_EN
        chk("reset stall_cnt", 32'(bus.stall_cnt), 32'h0);
        chk("reset freeze_cnt", 32'(bus.freeze_cnt), 32'h0);
`endif
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            drive(vt[i]);
            #1;
            chk($sformatf("v%0d fwd", i), 32'(bus.fwd), 32'(vt[i].efwd));
            chk($sformatf("v%0d stall", i), 32'(bus.stall), 32'(vt[i].est));
            chk($sformatf("v%0d freeze", i), 32'(bus.freeze), 32'(vt[i].efz));
`ifdef FWD_STALL_CNT_EN
            chk($sformatf("v%0d stall_cnt", i), 32'(bus.stall_cnt), 32'(sc));
            chk($sformatf("v%0d freeze_cnt", i), 32'(bus.freeze_cnt), 32'(fc));
            if (vt[i].est && sc < CMAX) sc++;
            if (vt[i].efz && fc < CMAX) fc++;
`endif
        end

        // Reset in the middle of a freeze drops all state at once
        reset = 1'b1;
        #1;
        chk("mid-freeze reset fwd", 32'(bus.fwd), 32'h0);
        chk("mid-freeze reset freeze", 32'(bus.freeze), 32'h0);
        chk("mid-freeze reset stall", 32'(bus.stall), 32'h0);
`ifdef FWD_STALL_CNT_EN
        chk("mid-freeze reset stall_cnt", 32'(bus.stall_cnt), 32'h0);
        chk("mid-freeze reset freeze_cnt", 32'(bus.freeze_cnt), 32'h0);
`endif
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        #1;
        chk("post-reset freeze", 32'(bus.freeze), 32'h0);
        chk("post-reset fwd", 32'(bus.fwd), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard unit for the 5-stage pipelined CPU. It tracks in-flight register writes in its own EX/MEM shadow stages and produces a forwarding select for each of NPORTS decode-stage source operands. It also generates the load-use stall, the memory-wait freeze and flush bubbles. It sits beside the ID stage and drives the operand muxes and the pipeline-register enables.

## Interface
Parameters:
- NPORTS, 2, number of decode-stage source operands
- AW, 5, register-number width; register 0 is hard-wired zero
- CW, 16, width of the statistics counters (only with FWD_STALL_CNT_EN)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- d_valid  in  1  instruction present in ID
- d_wreg  in  1  ID instruction writes a register
- d_m2reg  in  1  ID instruction is a load
- d_rn  in  AW  ID destination register
- d_rs  in  NPORTS*AW  source register of port p, in bits [p*AW +: AW]
- d_use  in  NPORTS  port p actually reads its register
- flush  in  1  kill the ID instruction (taken branch)
- mem_ready  in  1  data memory has completed the access in MEM
- fwd  out  2*NPORTS  select for port p, in bits [2p +: 2]
- stall  out  1  hold PC and IF/ID, inject bubble into EX
- freeze  out  1  hold the whole pipeline
- stall_cnt  out  CW  load-use stall cycles (macro only)
- freeze_cnt  out  CW  freeze cycles (macro only)

## Operation
- Internal state: two stage records, E and M, each {v, w, m2, rn}.
- fwd encoding: 00 = register file, 01 = EX ALU result, 10 = MEM ALU result, 11 = MEM load data.
- Per port p, with rs = d_rs[p]:
  - The select is 00 if !d_use[p] or rs==0.
  - EX hit is E.v & E.w & E.rn==rs. An EX hit with ~E.m2 gives 01. An EX hit with E.m2 gives 00 and raises the load-use condition for that port.
  - If there is no EX hit, MEM hit is M.v & M.w & M.rn==rs. A MEM hit gives 10 if ~M.m2 and 11 if M.m2.
  - An EX hit has priority over a MEM hit.
- freeze = M.v & M.m2 & ~mem_ready.
- stall = d_valid & (load-use condition on any port) & ~freeze.
- State update at the rising clock edge, in priority order:
  1. freeze: E and M hold.
  2. Otherwise M <= E.
  3. E <= bubble (v=0) if stall or flush, else E <= {d_valid, d_wreg, d_m2reg, d_rn}.
- Stall and flush together: E becomes a bubble. No double bubble results, because flush is an external decision.
- Freeze with a pending load-use condition: stall is 0. The condition re-evaluates after the freeze ends.
- d_wreg with d_rn==0: tracked, but it can never match, because rs==0 always selects 00.

## Timing
- fwd, stall and freeze are combinational from E/M state and same-cycle ID inputs. There are no registered outputs.
- A load-use stall lasts exactly one cycle. The next cycle the load is in M and the select becomes 11, unless a freeze intervenes.
- Freeze lasts for as long as mem_ready is low with a load in M. Selects stay valid and stable during freeze.
- Reset:
  - E.v and M.v are cleared.
  - fwd = 0, stall = 0, freeze = 0.
  - Counters are cleared.
  - Reset mid-freeze or mid-stall drops all state immediately.

## Configuration
- FWD_STALL_CNT_EN defined:
  - stall_cnt and freeze_cnt exist.
  - Each increments by 1 on every clock edge where the corresponding output is high.
  - Both saturate at 2^CW-1.
  - Both clear only on reset.
- Not defined: both ports and their counters are absent. All other behaviour is identical.

## Structure
- Package fwd_pkg:
  - select constants FWD_REG, FWD_EX, FWD_MEM_ALU, FWD_MEM_LOAD
  - the stage-record typedef {v, w, m2, rn}, with AW defaulting to 5
- Sub-module fwd_port_sel:
  - purely combinational
  - inputs: one rs, one use bit, and the E/M records
  - outputs: the 2-bit select and a load-use bit
  - instantiated NPORTS times in a generate loop
- The top level holds the stage registers, the freeze/stall/flush priority and the optional counters.

## Test plan
- **ALU back-to-back, EX forward:** ID issues add r3 (w=1, m2=0). Next cycle, ID uses rs0=3, rs1=4. Required: fwd port0=01, port1=00, stall=0. One cycle later, with ID using rs1=3: port1=10.
- **Load-use:** ID issues lw r5. Next cycle, ID uses rs0=5. Required: stall=1 for exactly one cycle and E becomes a bubble. The following cycle has fwd port0=11 and stall=0.
- **Priority:** E writes r7 (ALU) and M writes r7 (ALU). ID rs0=7 gives 01. Then E writes r0 while ID rs0=0: the result is 00.
- **Memory wait:** a load is in M with mem_ready=0 for 3 cycles. Required: freeze=1 for 3 cycles with E/M unchanged, stall=0 even with a load-use pending, and freeze_cnt=3 when the macro is on.
- **Flush with stall:** flush=1 and the load-use condition are both active in the same cycle. Required: E becomes a bubble and M <= E. Then assert reset mid-freeze: the next cycle has freeze=0, all fwd=00 and stall_cnt=0.
